bit1_beeper: RTL and testbench



---
 rtl/bit1_beeper_if.sv | 18 +
 rtl/bit1_beeper.sv | 177 +++++++++++++++++
 tb/tb_bit1_beeper.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bit1_beeper_if.sv
// Avalon-MM slave bus of the buzzer pattern generator.
interface bit1_beeper_if;
  logic [1:0]  avs_s1_address;
  logic        avs_s1_read;
  logic [15:0] avs_s1_readdata;
  logic        avs_s1_write;
  logic [15:0] avs_s1_writedata;

  modport master (
    output avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
    input  avs_s1_readdata
  );

  modport slave (
    input  avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
    output avs_s1_readdata
  );
endinterface

// File: rtl/bit1_beeper.sv
// Buzzer burst generator: a rising edge on the synchronized enable plays
// ON/OFF phases with a square-wave tone, finite bursts raise an interrupt.
module bit1_beeper #(
  parameter int TICK_DIV = 50000
) (
  input  logic         csi_clk,
  input  logic         csi_reset_n,
  bit1_beeper_if.slave avs,
  input  logic         coe_enable,
  output logic         coe_buzzer,
  output logic         ins_irq
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_OFF = 2'd2} state_t;

  state_t        state_r;
  logic [15:0]   halfper_r, ontime_r, offtime_r, readdata_r;
  logic [15:0]   tone_cnt_r, tick_cnt_r, phase_len_r;
  logic [7:0]    repeat_r, remaining_r;
  logic [PW-1:0] presc_r;
  logic          sync1_r, sync2_r, en_prev_r, tone_r, cont_r, buzzer_r, irq_r;

  logic          rise_s, tick_s, phase_done_s, tone_wrap_s, burst_done_s, ctrl_wr_s;
  logic [15:0]   ontime_eff_s, offtime_eff_s, rd_mux_s;

  // Event decode; zero phase lengths behave as one tick.
  always_comb begin
    rise_s       = sync2_r & ~en_prev_r;
    tick_s       = (presc_r == PRESC_LAST);
    phase_done_s = tick_s & (tick_cnt_r == (phase_len_r - 16'd1));
    tone_wrap_s  = (halfper_r != 16'd0) & (tone_cnt_r >= (halfper_r - 16'd1));
    burst_done_s = (state_r == ST_OFF) & sync2_r & phase_done_s & ~cont_r &
                   (remaining_r == 8'd1);
    ctrl_wr_s    = avs.avs_s1_write & (avs.avs_s1_address == 2'd3);
    if (ontime_r == 16'd0) begin
      ontime_eff_s = 16'd1;
    end else begin
      ontime_eff_s = ontime_r;
    end
    if (offtime_r == 16'd0) begin
      offtime_eff_s = 16'd1;
    end else begin
      offtime_eff_s = offtime_r;
    end
  end

  // Read data select.
  always_comb begin
    rd_mux_s = 16'd0;
    case (avs.avs_s1_address)
      2'd0:    rd_mux_s = halfper_r;
      2'd1:    rd_mux_s = ontime_r;
      2'd2:    rd_mux_s = offtime_r;
      2'd3:    rd_mux_s = {6'd0, irq_r, (state_r != ST_IDLE), repeat_r};
      default: rd_mux_s = 16'd0;
    endcase
  end

  // Register file, interrupt flag and registered read port.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      halfper_r  <= 16'd0;
      ontime_r   <= 16'd0;
      offtime_r  <= 16'd0;
      repeat_r   <= 8'd0;
      irq_r      <= 1'b0;
      readdata_r <= 16'd0;
    end else begin
      if (avs.avs_s1_write) begin
        case (avs.avs_s1_address)
          2'd0:    halfper_r <= avs.avs_s1_writedata;
          2'd1:    ontime_r  <= avs.avs_s1_writedata;
          2'd2:    offtime_r <= avs.avs_s1_writedata;
          2'd3:    repeat_r  <= avs.avs_s1_writedata[7:0];
          default: halfper_r <= halfper_r;
        endcase
      end
      // Completion beats a simultaneous clear.
      if (burst_done_s) begin
        irq_r <= 1'b1;
      end else if (ctrl_wr_s && avs.avs_s1_writedata[15]) begin
        irq_r <= 1'b0;
      end
      if (avs.avs_s1_read) begin
        readdata_r <= rd_mux_s;
      end
    end
  end

  // Enable synchronizer and edge-detect history.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      en_prev_r <= 1'b0;
    end else begin
      sync1_r   <= coe_enable;
      sync2_r   <= sync1_r;
      en_prev_r <= sync2_r;
    end
  end

  // Burst FSM with tone generator, phase timer and registered buzzer.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_r     <= ST_IDLE;
      tone_cnt_r  <= 16'd0;
      tone_r      <= 1'b0;
      presc_r     <= '0;
      tick_cnt_r  <= 16'd0;
      phase_len_r <= 16'd1;
      remaining_r <= 8'd0;
      cont_r      <= 1'b0;
      buzzer_r    <= 1'b0;
    end else begin
      buzzer_r <= (state_r == ST_ON) && (halfper_r != 16'd0) && tone_r;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_r     <= ST_ON;
            remaining_r <= repeat_r;
            cont_r      <= (repeat_r == 8'd0);
            tone_cnt_r  <= 16'd0;
            tone_r      <= 1'b1;
            presc_r     <= '0;
            tick_cnt_r  <= 16'd0;
            phase_len_r <= ontime_eff_s;
          end
        end
        ST_ON, ST_OFF: begin
          if (!sync2_r) begin
            state_r <= ST_IDLE;
          end else begin
            if (tone_wrap_s) begin
              tone_cnt_r <= 16'd0;
              tone_r     <= ~tone_r;
            end else if (halfper_r != 16'd0) begin
              tone_cnt_r <= tone_cnt_r + 16'd1;
            end
            if (phase_done_s) begin
              presc_r    <= '0;
              tick_cnt_r <= 16'd0;
              if (state_r == ST_ON) begin
                state_r     <= ST_OFF;
                phase_len_r <= offtime_eff_s;
              end else if (burst_done_s) begin
                state_r <= ST_IDLE;
              end else begin
                if (!cont_r) begin
                  remaining_r <= remaining_r - 8'd1;
                end
                state_r     <= ST_ON;
                tone_r      <= 1'b1;
                tone_cnt_r  <= 16'd0;
                phase_len_r <= ontime_eff_s;
              end
            end else if (tick_s) begin
              presc_r    <= '0;
              tick_cnt_r <= tick_cnt_r + 16'd1;
            end else begin
              presc_r <= presc_r + PW'(1);
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign coe_buzzer          = buzzer_r;
  assign ins_irq             = irq_r;
  assign avs.avs_s1_readdata = readdata_r;

endmodule

// File: tb/tb_bit1_beeper.sv
// Self-checking bench for bit1_beeper: register table, burst timing,
// continuous mode, enable-level corners and asynchronous reset.
module tb_bit1_beeper;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic buz;
  logic irq;

  bit1_beeper_if avs();

  bit1_beeper #(.TICK_DIV(TD)) dut (
    .csi_clk     (clk),
    .csi_reset_n (rst_n),
    .avs         (avs),
    .coe_enable  (en),
    .coe_buzzer  (buz),
    .ins_irq     (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [1:0] addr; logic [15:0] data; } rd_exp_t;
  rd_exp_t exp_q[$];
  logic    rd_seen;

  typedef struct { logic [1:0] addr; logic [15:0] wdata; logic [15:0] rexp; } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {15'd0, act}, {15'd0, exp});
  endtask

  // Read scoreboard: expectations queued by rd(), compared when data is due.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen <= 1'b0;
    else        rd_seen <= avs.avs_s1_read;
  end

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got 0x%04h expected no read", avs.avs_s1_readdata);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rd_addr%0d", e.addr), avs.avs_s1_readdata, e.data);
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    avs.avs_s1_address   = a;
    avs.avs_s1_writedata = d;
    avs.avs_s1_write     = 1'b1;
    @(negedge clk);
    avs.avs_s1_write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp);
    rd_exp_t e;
    @(negedge clk);
    e.addr = a;
    e.data = exp;
    exp_q.push_back(e);
    avs.avs_s1_address = a;
    avs.avs_s1_read    = 1'b1;
    @(negedge clk);
    avs.avs_s1_read    = 1'b0;
  endtask

  // Drop enable long enough to clear the edge detector, then raise it just
  // after a rising edge so the next edge is cycle 1 of the enable latency.
  task automatic restart();
    @(posedge clk); #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic exp_b;

    vecs[0] = '{2'd0, 16'h1234, 16'h1234};
    vecs[1] = '{2'd1, 16'hABCD, 16'hABCD};
    vecs[2] = '{2'd2, 16'h0001, 16'h0001};
    vecs[3] = '{2'd3, 16'h7F05, 16'h0005};
    vecs[4] = '{2'd3, 16'h00FF, 16'h00FF};
    vecs[5] = '{2'd3, 16'h8003, 16'h0003};
    vecs[6] = '{2'd0, 16'hFFFF, 16'hFFFF};

    rst_n = 1'b0;
    en    = 1'b0;
    avs.avs_s1_address   = 2'd0;
    avs.avs_s1_read      = 1'b0;
    avs.avs_s1_write     = 1'b0;
    avs.avs_s1_writedata = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_buz", buz, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    check("rst_readdata", avs.avs_s1_readdata, 16'h0000);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a), 16'h0000);

    // Register write / read-back table.
    for (int i = 0; i < 7; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].rexp);
    end
    chk1("table_buz", buz, 1'b0);
    chk1("table_irq", irq, 1'b0);

    // Finite burst: 2 x (12 ON clocks toggling every 2, 8 OFF clocks).
    wr(2'd0, 16'd2);
    wr(2'd1, 16'd3);
    wr(2'd2, 16'd2);
    wr(2'd3, 16'd2);
    @(posedge clk); #1;
    en = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      exp_b = 1'b0;
      if (k >= 4 && k <= 43) begin
        int m;
        m = (k - 4) % 20;
        exp_b = (m < 12) && (((m / 2) % 2) == 0);
      end
      chk1($sformatf("burst_buz_c%0d", k), buz, exp_b);
      chk1($sformatf("burst_irq_c%0d", k), irq, (k >= 43));
    end
    rd(2'd3, 16'h0202);
    wr(2'd3, 16'h8002);
    chk1("irq_clear", irq, 1'b0);
    rd(2'd3, 16'h0002);

    // Enable held high after completion: no restart.
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (buz !== 1'b0 || irq !== 1'b0) bad++;
    end
    check("held_no_restart", 16'(bad), 16'd0);
    rd(2'd3, 16'h0002);

    // Muted minimum burst after a new rise: 2*TD clocks, irq on completion.
    wr(2'd0, 16'd0);
    wr(2'd1, 16'd0);
    wr(2'd2, 16'd0);
    wr(2'd3, 16'd1);
    restart();
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("mute_buz_c%0d", k), buz, 1'b0);
      chk1($sformatf("mute_irq_c%0d", k), irq, (k >= 11));
    end
    rd(2'd3, 16'h0201);
    wr(2'd3, 16'h8001);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (buz !== 1'b0 || irq !== 1'b0) bad++;
    end
    check("mute_no_restart", 16'(bad), 16'd0);
    rd(2'd3, 16'h0001);

    // Continuous mode for 200 clocks, then enable falls.
    wr(2'd0, 16'd1);
    wr(2'd1, 16'd1);
    wr(2'd2, 16'd1);
    wr(2'd3, 16'd0);
    restart();
    bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      exp_b = (k >= 4) && (((k - 4) % 8) < 4) && (((k - 4) % 2) == 0);
      if (buz !== exp_b || irq !== 1'b0) bad++;
    end
    check("cont_pattern", 16'(bad), 16'd0);
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk1("cont_stop_buz", buz, 1'b0);
    chk1("cont_stop_irq", irq, 1'b0);
    rd(2'd3, 16'h0000);

    // Asynchronous reset in the middle of an ON phase with irq pending.
    wr(2'd0, 16'd2);
    wr(2'd1, 16'd3);
    wr(2'd2, 16'd2);
    wr(2'd3, 16'd1);
    restart();
    repeat (25) @(posedge clk);
    #1;
    chk1("pre_rst_irq", irq, 1'b1);
    restart();
    repeat (5) @(posedge clk);
    #1;
    chk1("pre_rst_buz", buz, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_buz", buz, 1'b0);
    chk1("async_rst_irq", irq, 1'b0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a), 16'h0000);
    chk1("post_rst_buz", buz, 1'b0);
    chk1("post_rst_irq", irq, 1'b0);

    repeat (2) @(negedge clk);
    check("rd_queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
